pc_gen_unit: RTL and testbench

Parametrised program-counter generator for the npc core: owns the architectural fetch PC register and resolves the next PC from sequential flow, all RV64 branch/jump types, and trap/mret redirects. It sits between the execute stage (branch resolution) and the instruction-fetch stage (valid/ready request). Compared with the purely combinational next-PC adders, it adds PC state, stall handling, redirect priority, misaligned-target detection and a downstream flush pulse.

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/pc_gen_unit_if.sv | 39 +++
 rtl/pc_target_calc.sv | 52 +++++
 rtl/pc_gen_unit.sv | 93 +++++++++
 tb/tb_pc_gen_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the npc program-counter generator.
package pc_gen_pkg;

    localparam int unsigned BR_TYPE_W = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Sequential fetch always advances one 32-bit word; compressed stepping is
    // handled inside fetch.
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [BR_TYPE_W-1:0] {
        BrNone = 4'd0,
        BrJal  = 4'd1,
        BrJalr = 4'd2,
        BrBeq  = 4'd3,
        BrBne  = 4'd4,
        BrBlt  = 4'd5,
        BrBge  = 4'd6,
        BrBltu = 4'd7,
        BrBgeu = 4'd8
    } br_type_e;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Execute/trap redirect inputs and fetch-request outputs of pc_gen_unit.
interface pc_gen_unit_if
    import pc_gen_pkg::*;
#(
    parameter int unsigned PC_W = 32,
    parameter int unsigned XLEN = 64
);
    logic                 if_ready;
    logic                 br_valid;
    logic [BR_TYPE_W-1:0] br_type;
    logic                 br_eq;
    logic                 br_lt;
    logic                 br_ltu;
    logic [PC_W-1:0]      br_pc;
    logic [XLEN-1:0]      br_src1;
    logic [XLEN-1:0]      br_imm;
    logic                 trap_valid;
    logic [PC_W-1:0]      trap_pc;

    logic [PC_W-1:0]      pc;
    logic                 pc_valid;
    logic                 flush;
    logic                 br_taken;
    logic                 misalign_exc;
    logic [PC_W-1:0]      misalign_tval;

    modport master (
        output if_ready, br_valid, br_type, br_eq, br_lt, br_ltu, br_pc, br_src1, br_imm,
               trap_valid, trap_pc,
        input  pc, pc_valid, flush, br_taken, misalign_exc, misalign_tval
    );

    modport slave (
        input  if_ready, br_valid, br_type, br_eq, br_lt, br_ltu, br_pc, br_src1, br_imm,
               trap_valid, trap_pc,
        output pc, pc_valid, flush, br_taken, misalign_exc, misalign_tval
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch resolution: taken decision, target address and
// alignment check. Assumes PC_W < XLEN.
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned XLEN  = 64,
    parameter bit          C_EXT = 1'b0
) (
    input  logic                 br_valid,
    input  logic [BR_TYPE_W-1:0] br_type,
    input  logic                 br_eq,
    input  logic                 br_lt,
    input  logic                 br_ltu,
    input  logic [PC_W-1:0]      br_pc,
    input  logic [XLEN-1:0]      br_src1,
    input  logic [XLEN-1:0]      br_imm,
    output logic                 taken,
    output logic [PC_W-1:0]      target,
    output logic                 misaligned
);

    logic [XLEN-1:0] jalr_sum;
    logic            cond;
    logic            unused_sum;

    assign jalr_sum   = br_src1 + br_imm;
    assign unused_sum = ^{jalr_sum[XLEN-1:PC_W], jalr_sum[0]};

    always_comb begin
        cond   = 1'b0;
        target = br_pc + br_imm[PC_W-1:0];
        case (br_type)
            BrJal:  cond = 1'b1;
            BrJalr: begin
                cond   = 1'b1;
                target = {jalr_sum[PC_W-1:1], 1'b0};
            end
            BrBeq:  cond = br_eq;
            BrBne:  cond = !br_eq;
            BrBlt:  cond = br_lt;
            BrBge:  cond = !br_lt;
            BrBltu: cond = br_ltu;
            BrBgeu: cond = !br_ltu;
            default: cond = 1'b0;
        endcase
    end

    assign taken      = br_valid && cond;
    assign misaligned = C_EXT ? target[0] : target[1];

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register with trap > branch > misalign-hold > sequential priority
// and registered flush / br_taken / misalign pulses.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     XLEN     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter bit              C_EXT    = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    pc_gen_unit_if.slave  bus
);

    logic            taken;
    logic [PC_W-1:0] target;
    logic            misaligned;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            flush_q, flush_d;
    logic            br_taken_q, br_taken_d;
    logic            mis_q, mis_d;
    logic [PC_W-1:0] tval_q, tval_d;

    pc_target_calc #(
        .PC_W  (PC_W),
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_target_calc (
        .br_valid   (bus.br_valid),
        .br_type    (bus.br_type),
        .br_eq      (bus.br_eq),
        .br_lt      (bus.br_lt),
        .br_ltu     (bus.br_ltu),
        .br_pc      (bus.br_pc),
        .br_src1    (bus.br_src1),
        .br_imm     (bus.br_imm),
        .taken      (taken),
        .target     (target),
        .misaligned (misaligned)
    );

    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        flush_d    = 1'b0;
        br_taken_d = 1'b0;
        mis_d      = 1'b0;
        tval_d     = tval_q;
        if (bus.trap_valid) begin
            pc_d    = bus.trap_pc;
            flush_d = 1'b1;
        end else if (taken && !misaligned) begin
            pc_d       = target;
            flush_d    = 1'b1;
            br_taken_d = 1'b1;
        end else if (taken) begin
            // Hold pc; the trap unit redirects with trap_valid afterwards.
            mis_d  = 1'b1;
            tval_d = target;
        end else if (pc_valid_q && bus.if_ready) begin
            pc_d = pc_q + PC_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            br_taken_q <= 1'b0;
            mis_q      <= 1'b0;
            tval_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            br_taken_q <= br_taken_d;
            mis_q      <= mis_d;
            tval_q     <= tval_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.flush         = flush_q;
    assign bus.br_taken      = br_taken_q;
    assign bus.misalign_exc  = mis_q;
    assign bus.misalign_tval = tval_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: one C_EXT=0 instance (main) and one C_EXT=1
// instance used for the 2-byte-aligned JALR case.
module tb_pc_gen_unit;
    import pc_gen_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_gen_unit_if #(.PC_W(32), .XLEN(64)) if0 ();
    pc_gen_unit_if #(.PC_W(32), .XLEN(64)) if1 ();

    pc_gen_unit #(.PC_W(32), .XLEN(64), .RESET_PC(32'h8000_0000), .C_EXT(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    pc_gen_unit #(.PC_W(32), .XLEN(64), .RESET_PC(32'h8000_0000), .C_EXT(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        if0.br_valid   = 1'b0;
        if0.br_type    = 4'd0;
        if0.br_eq      = 1'b0;
        if0.br_lt      = 1'b0;
        if0.br_ltu     = 1'b0;
        if0.br_pc      = '0;
        if0.br_src1    = '0;
        if0.br_imm     = '0;
        if0.trap_valid = 1'b0;
        if0.trap_pc    = '0;
    endtask

    task automatic branch0(input logic [3:0] t, input logic [31:0] bpc, input logic [63:0] src1,
                           input logic [63:0] imm, input logic eq, input logic lt,
                           input logic ltu);
        if0.br_valid = 1'b1;
        if0.br_type  = t;
        if0.br_pc    = bpc;
        if0.br_src1  = src1;
        if0.br_imm   = imm;
        if0.br_eq    = eq;
        if0.br_lt    = lt;
        if0.br_ltu   = ltu;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic fl,
                             input logic bt, input logic mis);
        check_val({tag, ".pc"}, 64'(if0.pc), 64'(pc));
        check_val({tag, ".flush"}, 64'(if0.flush), 64'(fl));
        check_val({tag, ".br_taken"}, 64'(if0.br_taken), 64'(bt));
        check_val({tag, ".misalign"}, 64'(if0.misalign_exc), 64'(mis));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle0();
        if0.if_ready   = 1'b1;
        if1.if_ready   = 1'b0;
        if1.br_valid   = 1'b0;
        if1.br_type    = 4'd0;
        if1.br_eq      = 1'b0;
        if1.br_lt      = 1'b0;
        if1.br_ltu     = 1'b0;
        if1.br_pc      = '0;
        if1.br_src1    = '0;
        if1.br_imm     = '0;
        if1.trap_valid = 1'b0;
        if1.trap_pc    = '0;
        tick();
        tick();
        check_out("reset", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        check_val("reset.pc_valid", 64'(if0.pc_valid), 64'd0);
        check_val("reset.tval", 64'(if0.misalign_tval), 64'd0);

        // Release: pc_valid rises, then sequential stepping
        rst_n = 1'b1;
        tick();
        check_out("rel1", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        check_val("rel1.pc_valid", 64'(if0.pc_valid), 64'd1);
        tick();
        check_val("rel2.pc", 64'(if0.pc), 64'h8000_0004);
        tick();
        check_val("rel3.pc", 64'(if0.pc), 64'h8000_0008);

        // BEQ taken, then sequential, then BEQ not taken
        branch0(BrBeq, 32'h8000_0010, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("beq_t", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        idle0();
        tick();
        check_out("beq_seq", 32'h8000_0004, 1'b0, 1'b0, 1'b0);
        branch0(BrBeq, 32'h8000_0010, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("beq_nt", 32'h8000_0008, 1'b0, 1'b0, 1'b0);

        // JALR misaligned with C_EXT=0: pc held despite if_ready
        branch0(BrJalr, 32'h8000_0000, 64'h8000_1003, 64'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("jalr_mis", 32'h8000_0008, 1'b0, 1'b0, 1'b1);
        check_val("jalr_mis.tval", 64'(if0.misalign_tval), 64'h8000_1002);
        idle0();
        if0.if_ready = 1'b0;
        // Same JALR on the C_EXT=1 instance is a legal redirect
        if1.br_valid = 1'b1;
        if1.br_type  = BrJalr;
        if1.br_src1  = 64'h8000_1003;
        if1.br_imm   = 64'd0;
        tick();
        check_out("mis_clear", 32'h8000_0008, 1'b0, 1'b0, 1'b0);
        check_val("cext.pc", 64'(if1.pc), 64'h8000_1002);
        check_val("cext.flush", 64'(if1.flush), 64'd1);
        check_val("cext.misalign", 64'(if1.misalign_exc), 64'd0);
        if1.br_valid = 1'b0;
        if0.if_ready = 1'b1;

        // Trap beats a taken JAL in the same cycle
        branch0(BrJal, 32'h8000_0008, 64'd0, 64'd8, 1'b0, 1'b0, 1'b0);
        if0.trap_valid = 1'b1;
        if0.trap_pc    = 32'h8000_0100;
        tick();
        check_out("trap", 32'h8000_0100, 1'b1, 1'b0, 1'b0);

        // Stall: pc and pc_valid stable for 4 cycles
        idle0();
        if0.if_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("stall", 32'h8000_0100, 1'b0, 1'b0, 1'b0);
            check_val("stall.pc_valid", 64'(if0.pc_valid), 64'd1);
        end

        // Out-of-range branch code acts as NONE
        branch0(4'd9, 32'h8000_0100, 64'd0, 64'h40, 1'b1, 1'b1, 1'b1);
        tick();
        check_out("type9", 32'h8000_0100, 1'b0, 1'b0, 1'b0);

        // BLTU taken during stall, then back-to-back JAL
        branch0(BrBltu, 32'h8000_0100, 64'd0, 64'h40, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("bltu", 32'h8000_0140, 1'b1, 1'b1, 1'b0);
        branch0(BrJal, 32'h8000_0140, 64'd0, 64'h20, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("b2b", 32'h8000_0160, 1'b1, 1'b1, 1'b0);

        // BGE with lt=1 not taken, then BGE lt=0 taken
        branch0(BrBge, 32'h8000_0160, 64'd0, 64'h10, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("bge_nt", 32'h8000_0160, 1'b0, 1'b0, 1'b0);
        branch0(BrBge, 32'h8000_0160, 64'd0, 64'h10, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("bge_t", 32'h8000_0170, 1'b1, 1'b1, 1'b0);

        // Target wrap-around
        branch0(BrJal, 32'hFFFF_FFFC, 64'd0, 64'd8, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("wrap", 32'h0000_0004, 1'b1, 1'b1, 1'b0);

        // Reset mid-stall discards a pending redirect
        branch0(BrJal, 32'h8000_0000, 64'd0, 64'h100, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        check_out("rst_mid", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        check_val("rst_mid.pc_valid", 64'(if0.pc_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
